// File: rtl/image_pingpong_bank.sv
// Double-buffered frame store: producer fills one bank while the consumer reads the other.
// Optional per-pixel write masking is enabled by defining IMG_BANK_WMASK_EN.
module image_pingpong_bank #(
    parameter int unsigned ROW_W = 3072,
    parameter int unsigned DEPTH = 128,
    parameter int unsigned PIX_W = 24,
    parameter int unsigned AW    = $clog2(DEPTH),
    parameter int unsigned NPIX  = ROW_W / PIX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    waddr,
    input  logic             we,
    input  logic [ROW_W-1:0] wdata,
    input  logic [NPIX-1:0]  wmask,
    input  logic             wdone,
    output logic             wr_ok,
    input  logic [AW-1:0]    raddr,
    input  logic             re,
    output logic [ROW_W-1:0] rdata,
    output logic             rvalid,
    input  logic             rdone,
    output logic             frame_rdy,
    output logic             wbank
);

    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

    logic             r_wsel;
    logic [1:0]       r_full;
    logic [ROW_W-1:0] r_rdata;
    logic             r_rvalid;
    logic [ROW_W-1:0] r_mem [2][DEPTH];

    logic w_rsel;
    logic w_wr_ok;
    logic w_frame_rdy;
    logic w_waddr_in;
    logic w_raddr_in;
    logic w_wr_acc;
    logic w_done_acc;
    logic w_rel_acc;
    logic w_rd_acc;

    assign w_rsel      = ~r_wsel;
    assign w_wr_ok     = !r_full[r_wsel];
    assign w_frame_rdy = r_full[w_rsel];
    assign w_waddr_in  = ({1'b0, waddr} < LP_DEPTH);
    assign w_raddr_in  = ({1'b0, raddr} < LP_DEPTH);
    assign w_wr_acc    = we && w_wr_ok && w_waddr_in;
    assign w_done_acc  = wdone && w_wr_ok;
    assign w_rel_acc   = rdone && w_frame_rdy;
    assign w_rd_acc    = re && w_frame_rdy;

    assign wr_ok     = w_wr_ok;
    assign frame_rdy = w_frame_rdy;
    assign wbank     = r_wsel;
    assign rdata     = r_rdata;
    assign rvalid    = r_rvalid;

    // Swap never coincides with an accepted wdone/rdone: both banks' flags gate them off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wsel <= 1'b0;
            r_full <= '0;
        end else begin
            if (r_full[r_wsel] && !r_full[w_rsel]) begin
                r_wsel <= w_rsel;
            end
            if (w_done_acc) begin
                r_full[r_wsel] <= 1'b1;
            end
            if (w_rel_acc) begin
                r_full[w_rsel] <= 1'b0;
            end
        end
    end

`ifdef IMG_BANK_WMASK_EN
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            for (int unsigned i = 0; i < NPIX; i++) begin
                if (wmask[i]) begin
                    r_mem[r_wsel][waddr][i*PIX_W +: PIX_W] <= wdata[i*PIX_W +: PIX_W];
                end
            end
        end
    end
`else
    logic w_unused_wmask;
    assign w_unused_wmask = ^wmask;

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wsel][waddr] <= wdata;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rdata <= w_raddr_in ? r_mem[w_rsel][raddr] : '0;
            end
        end
    end

endmodule

// File: tb/tb_image_pingpong_bank.sv
// Directed + randomized bench for image_pingpong_bank with a frame-level reference model.
// Expectations follow IMG_BANK_WMASK_EN the same way the design does.
module tb_image_pingpong_bank;

    localparam int ROW_W = 3072;
    localparam int DEPTH = 128;
    localparam int PIX_W = 24;
    localparam int AW    = 7;
    localparam int NPIX  = ROW_W / PIX_W;

    typedef logic [ROW_W-1:0] row_t;
    typedef logic [NPIX-1:0]  mask_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [AW-1:0] waddr = '0;
    logic          we = 1'b0;
    row_t          wdata = '0;
    mask_t         wmask = '0;
    logic          wdone = 1'b0;
    logic          wr_ok;
    logic [AW-1:0] raddr = '0;
    logic          re = 1'b0;
    row_t          rdata;
    logic          rvalid;
    logic          rdone = 1'b0;
    logic          frame_rdy;
    logic          wbank;

    image_pingpong_bank #(.ROW_W(ROW_W), .DEPTH(DEPTH), .PIX_W(PIX_W)) dut (
        .clk(clk), .rst_n(rst_n), .waddr(waddr), .we(we), .wdata(wdata), .wmask(wmask),
        .wdone(wdone), .wr_ok(wr_ok), .raddr(raddr), .re(re), .rdata(rdata),
        .rvalid(rvalid), .rdone(rdone), .frame_rdy(frame_rdy), .wbank(wbank)
    );

    always #5 clk = ~clk;

    row_t m_mem [2][DEPTH];
    row_t exp_rdata = '0;
    int   npass = 0;
    int   nfail = 0;
    int   ntotal = 0;

    task automatic chk_row(input string tag, input row_t obs, input row_t exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed(low128)=%h expected(low128)=%h", tag, obs[127:0], exp[127:0]);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic flags(input string tag, input logic e_wr_ok, input logic e_rdy, input logic e_wbank);
        chk_bit({tag, ".wr_ok"}, wr_ok, e_wr_ok);
        chk_bit({tag, ".frame_rdy"}, frame_rdy, e_rdy);
        chk_bit({tag, ".wbank"}, wbank, e_wbank);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic row_t rand_row();
        row_t r;
        for (int k = 0; k < ROW_W / 32; k++) r[k*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic mask_t rand_mask();
        mask_t m;
        for (int k = 0; k < NPIX / 32; k++) m[k*32 +: 32] = $urandom();
        return m;
    endfunction

    // Model: a masked write keeps old bits where the expanded pixel mask is 0.
    function automatic row_t merge(input row_t old_row, input row_t new_row, input mask_t m);
        row_t bits;
`ifdef IMG_BANK_WMASK_EN
        for (int p = 0; p < NPIX; p++) bits[p*PIX_W +: PIX_W] = {PIX_W{m[p]}};
`else
        bits = '1;
        if (m == '0) bits = '1;
`endif
        return (old_row & ~bits) | (new_row & bits);
    endfunction

    task automatic do_write(input int bank, input int row, input row_t d, input mask_t m, input logic done);
        we = 1'b1; waddr = AW'(row); wdata = d; wmask = m; wdone = done;
        tick();
        m_mem[bank][row] = merge(m_mem[bank][row], d, m);
        we = 1'b0; wdone = 1'b0;
    endtask

    task automatic do_read(input string tag, input int bank, input int row);
        re = 1'b1; raddr = AW'(row);
        tick();
        exp_rdata = m_mem[bank][row];
        chk_bit({tag, ".rvalid"}, rvalid, 1'b1);
        chk_row({tag, ".rdata"}, rdata, exp_rdata);
        re = 1'b0;
    endtask

    initial begin
        row_t  e5;
        int    order [DEPTH];
        int    tmp;
        int    j;
        int    rows3 [3];

        #2 rst_n = 1'b0;
        tick(); tick();
        flags("reset", 1'b1, 1'b0, 1'b0);
        chk_bit("reset.rvalid", rvalid, 1'b0);
        chk_row("reset.rdata", rdata, '0);
        rst_n = 1'b1;
        tick();

        // Nothing is readable yet: re and rdone must be ignored.
        re = 1'b1; raddr = 7'd3;
        tick();
        chk_bit("early_re.rvalid", rvalid, 1'b0);
        chk_row("early_re.rdata", rdata, '0);
        re = 1'b0; rdone = 1'b1;
        tick();
        rdone = 1'b0;
        flags("early_rdone", 1'b1, 1'b0, 1'b0);

        // Frame 0 into bank 0, last write shares its cycle with wdone.
        for (int r = 0; r < DEPTH; r++) begin
            do_write(0, r, {(ROW_W/8){8'(r)}}, '1, r == DEPTH - 1);
        end
        flags("wdone0_t", 1'b0, 1'b0, 1'b0);
        tick();
        flags("wdone0_t1", 1'b1, 1'b1, 1'b1);

        for (int r = 0; r < DEPTH; r++) do_read("rd_bank0", 0, r);
        tick();
        chk_bit("rd_idle.rvalid", rvalid, 1'b0);
        chk_row("rd_idle.rdata_hold", rdata, exp_rdata);

        // Frame 1 into bank 1 while bank 0 is still held.
        for (int r = 0; r < DEPTH; r++) do_write(1, r, rand_row(), '1, 1'b0);
        for (int n = 0; n < 20; n++) do_write(1, $urandom_range(DEPTH - 1), rand_row(), rand_mask(), 1'b0);
        do_write(1, 5, '1, '1, 1'b0);
        do_write(1, 5, '0, mask_t'(1), 1'b0);
        do_write(1, DEPTH - 1, rand_row(), '1, 1'b1);
        flags("wdone1_blocked", 1'b0, 1'b1, 1'b1);

        // Blocked write and wdone must have no effect.
        we = 1'b1; waddr = 7'd5; wdata = '1; wmask = '1; wdone = 1'b1;
        tick();
        we = 1'b0; wdone = 1'b0;
        flags("blocked_we", 1'b0, 1'b1, 1'b1);

        rdone = 1'b1;
        tick();
        rdone = 1'b0;
        flags("rdone_u", 1'b0, 1'b0, 1'b1);
        tick();
        flags("rdone_u1", 1'b1, 1'b1, 1'b0);

        for (int r = 0; r < DEPTH; r++) order[r] = r;
        for (int r = DEPTH - 1; r > 0; r--) begin
            j = $urandom_range(r);
            tmp = order[r]; order[r] = order[j]; order[j] = tmp;
        end
        for (int r = 0; r < DEPTH; r++) do_read("rd_bank1", 1, order[r]);

`ifdef IMG_BANK_WMASK_EN
        e5 = '1;
        e5[PIX_W-1:0] = '0;
`else
        e5 = '0;
`endif
        re = 1'b1; raddr = 7'd5;
        tick();
        re = 1'b0;
        chk_row("mask_row5", rdata, e5);
        exp_rdata = e5;

        // Bank 0 refill; wdone and rdone in the same cycle.
        rows3[0] = 0; rows3[1] = 64; rows3[2] = DEPTH - 1;
        for (int k = 0; k < 3; k++) do_write(0, rows3[k], rand_row(), rand_mask(), 1'b0);
        wdone = 1'b1; rdone = 1'b1;
        tick();
        wdone = 1'b0; rdone = 1'b0;
        flags("both_t", 1'b0, 1'b0, 1'b0);
        tick();
        flags("both_t1", 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) do_read("rd_refill", 0, rows3[k]);
        do_read("rd_keep", 0, 10);

        // Reset lands in the middle of a read burst.
        re = 1'b1; raddr = 7'd20;
        tick();
        chk_bit("burst.rvalid", rvalid, 1'b1);
        chk_row("burst.rdata", rdata, m_mem[0][20]);
        raddr = 7'd21;
        #2 rst_n = 1'b0;
        #1;
        chk_bit("async_rst.rvalid", rvalid, 1'b0);
        chk_row("async_rst.rdata", rdata, '0);
        flags("async_rst", 1'b1, 1'b0, 1'b0);
        re = 1'b0;
        tick();
        rst_n = 1'b1;
        re = 1'b1;
        tick();
        re = 1'b0;
        flags("post_rst", 1'b1, 1'b0, 1'b0);
        chk_bit("post_rst.rvalid", rvalid, 1'b0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
